// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - mips32 register file with merge writes, bypassed reads and load scoreboard
module regfile_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr_1,
  input  logic [ADDR_W-1:0] i_rd_addr_2,
  output logic [DATA_W-1:0] o_rd_data_1,
  output logic [DATA_W-1:0] o_rd_data_2,
  output logic              o_rd_busy_1,
  output logic              o_rd_busy_2,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [1:0]        i_wr_mode,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_claim_en,
  input  logic [ADDR_W-1:0] i_claim_addr,
  output logic              o_busy_any
);

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   r_rd_data_1;
  logic [DATA_W-1:0]   r_rd_data_2;
  logic                r_rd_busy_1;
  logic                r_rd_busy_2;
  logic                r_busy_any;

  logic [DATA_W-1:0]   w_regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [DATA_W-1:0]   w_mask;
  logic                w_wr_ok;
  logic                w_claim_ok;

  // Addresses past the last register exist only when NUM_REGS is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Register 0 is hardwired when the zero register is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify the write and claim requests and pick the lane mask for the merge.
  always_comb begin
    w_wr_ok    = i_wr_en && (i_wr_mode != 2'b11) && in_range(i_wr_addr) && !is_zero(i_wr_addr);
    w_claim_ok = i_claim_en && in_range(i_claim_addr) && !is_zero(i_claim_addr);
    case (i_wr_mode)
      MODE_WORD: w_mask = '1;
      MODE_HALF: w_mask = HALF_MASK;
      MODE_BYTE: w_mask = BYTE_MASK;
      default:   w_mask = '0;
    endcase
  end

  // Next-state register array and busy vector; the claim is applied last so it wins over a write.
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_regs_nxt[i_wr_addr] = (r_regs[i_wr_addr] & ~w_mask) | (i_wr_data & w_mask);
      w_busy_nxt[i_wr_addr] = 1'b0;
    end
    if (w_claim_ok) begin
      w_busy_nxt[i_claim_addr] = 1'b1;
    end
  end

  // Commit register contents and busy bits; reset drops all outstanding claims.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports sample the next-state view, which gives same-edge write bypass for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data_1 <= '0;
      r_rd_data_2 <= '0;
      r_rd_busy_1 <= 1'b0;
      r_rd_busy_2 <= 1'b0;
      r_busy_any  <= 1'b0;
    end else begin
      r_busy_any <= |w_busy_nxt;
      if (i_rd_en) begin
        r_rd_data_1 <= in_range(i_rd_addr_1) ? w_regs_nxt[i_rd_addr_1] : '0;
        r_rd_data_2 <= in_range(i_rd_addr_2) ? w_regs_nxt[i_rd_addr_2] : '0;
        r_rd_busy_1 <= in_range(i_rd_addr_1) ? w_busy_nxt[i_rd_addr_1] : 1'b0;
        r_rd_busy_2 <= in_range(i_rd_addr_2) ? w_busy_nxt[i_rd_addr_2] : 1'b0;
      end
    end
  end

  assign o_rd_data_1 = r_rd_data_1;
  assign o_rd_data_2 = r_rd_data_2;
  assign o_rd_busy_1 = r_rd_busy_1;
  assign o_rd_busy_2 = r_rd_busy_2;
  assign o_busy_any  = r_busy_any;

endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - self-checking bench for regfile_bank against a behavioural model
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr_1 = '0;
  logic [4:0]  rd_addr_2 = '0;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;
  logic        rd_busy_1;
  logic        rd_busy_2;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [1:0]  wr_mode = '0;
  logic [31:0] wr_data = '0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_addr = '0;
  logic        busy_any;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] e_d1, e_d2;
  logic        e_b1, e_b2, e_any;

  regfile_bank dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_en      (rd_en),
    .i_rd_addr_1  (rd_addr_1),
    .i_rd_addr_2  (rd_addr_2),
    .o_rd_data_1  (rd_data_1),
    .o_rd_data_2  (rd_data_2),
    .o_rd_busy_1  (rd_busy_1),
    .o_rd_busy_2  (rd_busy_2),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_mode    (wr_mode),
    .i_wr_data    (wr_data),
    .i_claim_en   (claim_en),
    .i_claim_addr (claim_addr),
    .o_busy_any   (busy_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    e_d1 = 0; e_d2 = 0; e_b1 = 0; e_b2 = 0; e_any = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d1"}, rd_data_1, e_d1);
    chk({tag, ".d2"}, rd_data_2, e_d2);
    chk({tag, ".b1"}, {31'b0, rd_busy_1}, {31'b0, e_b1});
    chk({tag, ".b2"}, {31'b0, rd_busy_2}, {31'b0, e_b2});
    chk({tag, ".any"}, {31'b0, busy_any}, {31'b0, e_any});
  endtask

  // One clock: drive at negedge, model the edge, check at the following negedge.
  task automatic cycle(input string tag, input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [1:0] wm, input logic [31:0] wd,
                       input logic ce, input logic [4:0] ca);
    logic [31:0] old_v;
    logic [31:0] new_v;
    int nb;
    rd_en = re; rd_addr_1 = a1; rd_addr_2 = a2;
    wr_en = we; wr_addr = wa; wr_mode = wm; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    @(posedge clk);
    if (we && wm != 2'd3 && wa != 5'd0) begin
      old_v = m_regs[wa];
      case (wm)
        2'd0:    new_v = wd;
        2'd1:    new_v = old_v - (old_v % 32'd65536) + (wd % 32'd65536);
        default: new_v = old_v - (old_v % 32'd256) + (wd % 32'd256);
      endcase
      m_regs[wa] = new_v;
      m_busy[wa] = 1'b0;
    end
    if (ce && ca != 5'd0) m_busy[ca] = 1'b1;
    if (re) begin
      e_d1 = m_regs[a1]; e_d2 = m_regs[a2];
      e_b1 = m_busy[a1]; e_b2 = m_busy[a2];
    end
    nb = 0;
    for (int i = 0; i < 32; i++) nb += int'(m_busy[i]);
    e_any = (nb > 0);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic mid_cycle_reset(input string tag);
    rd_en = 0; wr_en = 0; claim_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    mid_cycle_reset("reset");

    // word write then read
    cycle("wr_r5", 0, 0, 0, 1, 5, 2'd0, 32'hDEADBEEF, 0, 0);
    cycle("rd_r5", 1, 5, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("r5_data", rd_data_1, 32'hDEADBEEF);
    chk("r5_busy", {31'b0, rd_busy_1}, 32'h0);

    // merge modes on r7
    cycle("wr_r7", 0, 0, 0, 1, 7, 2'd0, 32'h12345678, 0, 0);
    cycle("byte_r7", 1, 7, 7, 1, 7, 2'd2, 32'hFFFFFFAB, 0, 0);
    chk("r7_byte", rd_data_1, 32'h123456AB);
    cycle("half_r7", 1, 7, 7, 1, 7, 2'd1, 32'h0000CDEF, 0, 0);
    chk("r7_half", rd_data_1, 32'h1234CDEF);
    cycle("rsvd_r7", 1, 7, 7, 1, 7, 2'd3, 32'h0, 0, 0);
    chk("r7_rsvd", rd_data_2, 32'h1234CDEF);

    // bypass on r3, both ports
    cycle("byp_r3", 1, 3, 3, 1, 3, 2'd0, 32'hA5A5A5A5, 0, 0);
    chk("r3_p1", rd_data_1, 32'hA5A5A5A5);
    chk("r3_p2", rd_data_2, 32'hA5A5A5A5);
    cycle("byp_r3b", 1, 3, 3, 1, 3, 2'd2, 32'h0000003C, 0, 0);
    chk("r3_byte", rd_data_1, 32'hA5A5A53C);

    // zero register
    cycle("zero_wr", 1, 0, 0, 1, 0, 2'd0, 32'hFFFFFFFF, 1, 0);
    chk("r0_data", rd_data_1, 32'h0);
    chk("r0_busy", {31'b0, rd_busy_2}, 32'h0);
    chk("r0_any", {31'b0, busy_any}, 32'h0);
    cycle("zero_rd", 1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("r0_data2", rd_data_2, 32'h0);

    // scoreboard on r9
    cycle("claim_r9", 1, 9, 0, 0, 0, 2'd0, 0, 1, 9);
    chk("r9_busy", {31'b0, rd_busy_1}, 32'h1);
    chk("r9_any", {31'b0, busy_any}, 32'h1);
    cycle("clwr_r9", 1, 9, 9, 1, 9, 2'd0, 32'h11112222, 1, 9);
    chk("r9_clwr_busy", {31'b0, rd_busy_2}, 32'h1);
    chk("r9_clwr_data", rd_data_2, 32'h11112222);
    cycle("wr_r9", 1, 9, 9, 1, 9, 2'd0, 32'h33334444, 0, 0);
    chk("r9_wr_busy", {31'b0, rd_busy_1}, 32'h0);
    chk("r9_wr_any", {31'b0, busy_any}, 32'h0);

    // hold while rd_en is low
    cycle("hold_a", 1, 9, 3, 0, 0, 2'd0, 0, 1, 9);
    cycle("hold_b", 0, 7, 5, 1, 9, 2'd0, 32'h77777777, 0, 0);
    chk("hold_d1", rd_data_1, 32'h33334444);
    chk("hold_b1", {31'b0, rd_busy_1}, 32'h1);
    cycle("hold_c", 0, 1, 2, 0, 0, 2'd0, 0, 1, 12);

    // reset with an outstanding claim, then a normal write
    mid_cycle_reset("reset2");
    chk("reset2_any", {31'b0, busy_any}, 32'h0);
    cycle("post_rst", 1, 9, 12, 1, 9, 2'd0, 32'h00000055, 0, 0);
    chk("post_rst_d", rd_data_1, 32'h00000055);
    chk("post_rst_b", {31'b0, rd_busy_2}, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom(),
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      if (n == 200) mid_cycle_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised, clocked general-purpose register file for the mips32 datapath. It replaces the event-driven register block with the following:
- synchronous writes with word, halfword and byte merge modes;
- registered dual reads with same-cycle write bypass;
- a hardwired zero register;
- a per-register pending-load scoreboard, which the pipeline uses to stall load-use hazards.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 16 and at least 16.
- NUM_REGS, 32, number of registers; must be at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and claims.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read enable for both read ports.
- rd_addr_1  in  ADDR_W  read port 1 address.
- rd_addr_2  in  ADDR_W  read port 2 address.
- rd_data_1  out  DATA_W  registered read data, port 1.
- rd_data_2  out  DATA_W  registered read data, port 2.
- rd_busy_1  out  1  registered pending-load flag for rd_addr_1.
- rd_busy_2  out  1  registered pending-load flag for rd_addr_2.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_mode  in  2  write mode: 00 word, 01 low halfword, 10 low byte, 11 reserved (no write).
- wr_data  in  DATA_W  write data.
- claim_en  in  1  marks claim_addr as pending (load issued).
- claim_addr  in  ADDR_W  register targeted by the outstanding load.
- busy_any  out  1  OR of all busy bits, registered.

## Operation
- Storage: NUM_REGS x DATA_W flops plus a NUM_REGS-bit busy vector.
- Write (wr_en=1, wr_mode!=11, wr_addr<NUM_REGS): merge on the clock edge.
  - 00: reg := wr_data.
  - 01: reg[15:0] := wr_data[15:0]; upper bits kept.
  - 10: reg[7:0] := wr_data[7:0]; upper bits kept.
  - A write also clears busy[wr_addr].
- Ignored writes: wr_mode=11 writes nothing and leaves busy unchanged. Out-of-range addresses are ignored.
- Zero register: when ZERO_REG=1, writes and claims to address 0 are discarded, and busy[0] stays 0.
- Claims: claim_en=1 sets busy[claim_addr].
  - A claim and a write to the same address in the same cycle leave busy=1 (claim wins) and the data is still written.
- Reads, when rd_en=1, capture the following on the edge:
  - rd_data_n := next-state value of register rd_addr_n. This is the bypass: a same-cycle write to the same address returns the merged value, not the stale one.
  - rd_busy_n := next-state busy bit, with the same claim/write precedence.
  - Both ports may address the same register.
- Reads with rd_en=0: outputs hold their previous values.
- Out-of-range read address: data 0, busy 0.
- busy_any reflects the busy vector after the edge.

## Timing
- Write latency: the register holds the new value one edge after wr_en.
- Read latency: 1 cycle from address to rd_data/rd_busy.
- Bypass adds no extra cycle: a write and a read of the same address on edge N give merged data at edge N.
- Reset (rst_n=0, asynchronous) forces, immediately and without waiting for a clock:
  - all registers to 0;
  - all busy bits to 0;
  - rd_data_1, rd_data_2, rd_busy_1, rd_busy_2 and busy_any to 0.
- Reset deassertion: the first edge with rst_n=1 performs normal operation.
- Reset during an outstanding claim drops the claim.
- No handshake back-pressure: every enabled request completes on its edge.

## Test plan
- Reset then read: rst_n low mid-cycle -> all outputs 0 immediately. Then write word 0xDEADBEEF to r5 and read r5 next cycle -> rd_data_1=0xDEADBEEF, rd_busy_1=0.
- Merge modes on r7, which holds 0x12345678:
  - wr_mode=10 with 0xFFFFFFAB -> 0x123456AB.
  - Then wr_mode=01 with 0x0000CDEF -> 0x1234CDEF.
  - Then wr_mode=11 with 0 -> unchanged.
- Bypass: same cycle write r3=0xA5A5A5A5 (word) and read r3 on both ports -> both rd_data = 0xA5A5A5A5 after that edge. Byte write to r3 with read -> merged value.
- Zero register: write 0xFFFFFFFF to r0 and claim r0 -> read r0 gives 0, rd_busy 0, busy_any 0.
- Scoreboard sequence on r9:
  - claim r9 -> read r9 shows rd_busy=1 and busy_any=1.
  - Claim r9 and write r9 in the same cycle -> busy stays 1, data updated.
  - Write r9 alone -> busy 0, busy_any 0.
- Hold and reset mid-operation:
  - rd_en=0 while addresses change -> outputs hold.
  - Assert rst_n=0 between edges with busy set -> outputs and busy cleared asynchronously; the next write after release works normally.
